// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues sram-like requests, tracks the single outstanding
// response, and drops responses that belong to a flushed fetch.
module fetch_ctrl (
  input  logic clk,
  input  logic resetn,
  input  logic if_fetch_en,
  input  logic inst_addr_ok,
  input  logic inst_data_ok,
  input  logic down_stall,
  input  logic exc_flush,
  input  logic bp_fail,
  output logic inst_req,
  output logic inst_valid,
  output logic seg_stall,
  output logic seg_refresh,
  output logic fail_flushed,
  output logic busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

  logic [1:0] state_q, state_d;
  logic       drop_q, drop_d;
  logic       fail_q;
  logic       flush;
  logic [1:0] resume;

  assign flush  = exc_flush | bp_fail;
  assign resume = if_fetch_en ? StReq : StIdle;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      StIdle: state_d = resume;
      StReq: begin
        // The request stays up until accepted; a flush only marks its response for discard.
        if (flush) drop_d = 1'b1;
        if (inst_addr_ok) state_d = StResp;
      end
      StResp: begin
        if (inst_data_ok) begin
          drop_d = 1'b0;
          if (!drop_q && !flush && down_stall) state_d = StHold;
          else                                 state_d = resume;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        if (flush || !down_stall) state_d = resume;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      drop_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      fail_q  <= bp_fail;
    end
  end

  assign inst_req     = (state_q == StReq);
  assign busy         = (state_q == StReq) || (state_q == StResp);
  assign inst_valid   = (state_q == StResp) & inst_data_ok & ~drop_q & ~flush;
  assign fail_flushed = fail_q;
  // Reset forces a refresh so the IF/PD register never holds stale data across reset.
  assign seg_refresh  = flush | ~resetn;
  assign seg_stall    = ~seg_refresh & (down_stall | ((state_q != StHold) & ~inst_valid));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, async-reset sequence and
// randomized traffic against a transaction-level reference model.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic resetn;
  logic if_fetch_en, inst_addr_ok, inst_data_ok, down_stall, exc_flush, bp_fail;
  logic inst_req, inst_valid, seg_stall, seg_refresh, fail_flushed, busy;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .if_fetch_en  (if_fetch_en),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .down_stall   (down_stall),
    .exc_flush    (exc_flush),
    .bp_fail      (bp_fail),
    .inst_req     (inst_req),
    .inst_valid   (inst_valid),
    .seg_stall    (seg_stall),
    .seg_refresh  (seg_refresh),
    .fail_flushed (fail_flushed),
    .busy         (busy)
  );

  typedef struct {
    logic fe, ao, dok, ds, ex, bp;
    logic req, val, stall, refr, ff, bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic fe, ao, dok, ds, ex, bp);
    if_fetch_en = fe; inst_addr_ok = ao; inst_data_ok = dok;
    down_stall = ds; exc_flush = ex; bp_fail = bp;
  endtask

  task automatic chk_all(input string tag, input logic req, val, stall, refr, ff, bsy);
    chk({tag, ".inst_req"}, inst_req, req);
    chk({tag, ".inst_valid"}, inst_valid, val);
    chk({tag, ".seg_stall"}, seg_stall, stall);
    chk({tag, ".seg_refresh"}, seg_refresh, refr);
    chk({tag, ".fail_flushed"}, fail_flushed, ff);
    chk({tag, ".busy"}, busy, bsy);
  endtask

  function automatic vec_t mk(input logic fe, ao, dok, ds, ex, bp,
                              input logic req, val, stall, refr, ff, bsy);
    vec_t v;
    v.fe = fe; v.ao = ao; v.dok = dok; v.ds = ds; v.ex = ex; v.bp = bp;
    v.req = req; v.val = val; v.stall = stall; v.refr = refr; v.ff = ff; v.bsy = bsy;
    return v;
  endfunction

  // Reference model: a request waiting for acceptance, a response awaited, discard mark,
  // and whether the pipeline register is holding delivered data.
  bit m_wait_addr, m_wait_data, m_discard, m_holding, m_prev_bp;

  initial begin
    //             fe ao do ds ex bp   req val stl ref ff bsy
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // idle -> req
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1)); // accepted
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1)); // waiting data
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1)); // data delivered
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1)); // bp_fail while waiting addr
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1)); // req held, fail_flushed
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1)); // late accept
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1)); // dropped response
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1)); // flush with data_ok
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1)); // accepted normally
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1)); // data under stall
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0)); // hold
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // 4th hold cycle, release
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1)); // new request
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1)); // accepted -> resp

    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk_all("reset", 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].fe, vecs[i].ao, vecs[i].dok, vecs[i].ds, vecs[i].ex, vecs[i].bp);
      #3;
      chk_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].val, vecs[i].stall,
              vecs[i].refr, vecs[i].ff, vecs[i].bsy);
      @(posedge clk); #1;
    end

    // Async reset mid-response, asserted between edges.
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("resp.busy_before", busy, 1'b1);
    resetn = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 1, 0, 0);
    @(posedge clk); #2;
    resetn = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 1, 0, 0, 0); // late data_ok after release
    #3;
    chk_all("late_data", 0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("after_late.busy", busy, 1'b0);
    @(posedge clk); #1;

    m_wait_addr = 0; m_wait_data = 0; m_discard = 0; m_holding = 0; m_prev_bp = 0;
    for (int c = 0; c < 3000; c++) begin
      logic fl, e_val, e_stall;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 9) == 0);
      #3;
      fl      = exc_flush | bp_fail;
      e_val   = m_wait_data & inst_data_ok & !m_discard & !fl;
      e_stall = !fl & (down_stall | (!m_holding & !e_val));
      chk_all("rand", m_wait_addr, e_val, e_stall, fl, m_prev_bp, m_wait_addr | m_wait_data);
      m_prev_bp = bp_fail;
      if (m_wait_addr) begin
        if (fl) m_discard = 1;
        if (inst_addr_ok) begin m_wait_addr = 0; m_wait_data = 1; end
      end else if (m_wait_data) begin
        if (inst_data_ok) begin
          m_wait_data = 0;
          m_discard   = 0;
          if (e_val && down_stall) m_holding = 1;
          else m_wait_addr = if_fetch_en;
        end else if (fl) m_discard = 1;
      end else if (m_holding) begin
        if (fl || !down_stall) begin m_holding = 0; m_wait_addr = if_fetch_en; end
      end else begin
        m_wait_addr = if_fetch_en;
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 resetn  input  1  reset, asynchronous, active-low; forces the reset state immediately and holds it while low.
REQ-003 if_fetch_en  input  1  IF stage has a valid PC to fetch this cycle.
REQ-004 inst_addr_ok  input  1  instruction memory accepted the current request (sram-like handshake).
REQ-005 inst_data_ok  input  1  instruction memory returns data for the oldest accepted request.
REQ-006 down_stall  input  1  PD/ID cannot accept a new instruction this cycle.
REQ-007 exc_flush  input  1  exception/ERET redirect; highest priority flush.
REQ-008 bp_fail  input  1  EX-or-later branch prediction failure redirect.
REQ-009 inst_req  output  1  request to instruction memory; is a registered state decode.
REQ-010 inst_valid  output  1  returned data is accepted for the PD stage this cycle.
REQ-011 seg_stall  output  1  stall to the IF/PD pipeline register.
REQ-012 seg_refresh  output  1  refresh to the IF/PD pipeline register.
REQ-013 fail_flushed  output  1  registered copy of bp_fail, one-cycle delayed.
REQ-014 busy  output  1  a request is issued or outstanding (state != IDLE and != HOLD).

Function
REQ-015 FSM states SHALL be IDLE, REQ, RESP, HOLD, plus a 1-bit drop flag.
REQ-016 IDLE: if_fetch_en=1 -> REQ next cycle; else stay.
REQ-017 REQ: inst_req=1 held until inst_addr_ok; on addr_ok -> RESP; the request SHALL NOT be withdrawn before addr_ok, even on flush.
REQ-018 RESP: on inst_data_ok with drop=0 -> inst_valid=1 same cycle; next state HOLD if down_stall=1, else REQ if if_fetch_en=1, else IDLE.
REQ-019 RESP: on inst_data_ok with drop=1 -> inst_valid=0, drop cleared, next state REQ if if_fetch_en=1 else IDLE.
REQ-020 HOLD: data retained by the pipeline register; leave when down_stall=0 -> REQ if if_fetch_en=1 else IDLE; no new request issued while in HOLD.
REQ-021 flush = exc_flush | bp_fail; seg_refresh SHALL equal flush combinationally (same cycle).
REQ-022 flush in REQ or RESP (without same-cycle data_ok) SHALL set drop=1; state progression continues so the in-flight response is consumed and discarded.
REQ-023 flush in RESP coinciding with inst_data_ok: inst_valid=0, drop stays 0, next state REQ if if_fetch_en=1 else IDLE.
REQ-024 flush in HOLD: -> IDLE (or REQ if if_fetch_en=1) next cycle, drop unchanged (0).
REQ-025 flush in IDLE: state unaffected apart from normal if_fetch_en transition.
REQ-026 seg_stall = !flush & (down_stall | (state!=HOLD & !inst_valid)); flush overrides stall.
REQ-027 At most one request outstanding; drop flag width 1 is sufficient and SHALL never need to count above 1.
REQ-028 fail_flushed <= bp_fail each cycle, independent of stall.
REQ-029 Simultaneous exc_flush and bp_fail SHALL behave as a single flush.

Reset
REQ-030 resetn=0: state=IDLE, drop=0, fail_flushed=0; inst_req=0, inst_valid=0, busy=0; seg_refresh=1 and seg_stall=0 while resetn=0.
REQ-031 Reset mid-transaction (REQ/RESP) SHALL abandon the transaction; the first cycle after release behaves as IDLE.

Verification
REQ-032 Normal fetch: if_fetch_en=1, addr_ok 1 cycle after req, data_ok 2 cycles later, down_stall=0 -> inst_req high 1 cycle, inst_valid pulses once, back-to-back REQ.
REQ-033 Flush while waiting addr_ok: bp_fail in REQ, addr_ok 3 cycles later, data_ok next -> inst_req held through, inst_valid stays 0, seg_refresh=1 in flush cycle, fail_flushed=1 the cycle after.
REQ-034 Flush coincident with data_ok: exc_flush and data_ok same cycle -> inst_valid=0, drop=0, next response accepted normally.
REQ-035 Downstream stall: data_ok with down_stall=1 for 4 cycles -> state HOLD 4 cycles, inst_req=0, seg_stall=1, then REQ.
REQ-036 Async reset: drop resetn mid-RESP between clock edges -> inst_req/busy fall immediately; after release, late data_ok is ignored (inst_valid=0).
